// File: rtl/rvcpu_pkg.sv
// Shared rvcpu pipeline types: execute/memory stage records and memory-op decode.
package rvcpu;

    localparam int Width = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic        store;
        mem_size_t   size;
        logic        is_unsigned;
    } mem_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rd_valid;
        logic        is_mem;
        logic [3:0]  op;
        logic [31:0] addr;
    } stage_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_valid;
        logic [31:0] data;
        logic        misaligned;
    } stage_mem_t;

    // op[3] selects store; op[2:0] is funct3, where bit 2 marks the unsigned loads.
    function automatic mem_op_t decode_op(input logic [3:0] op);
        mem_op_t d;
        d.store       = op[3];
        d.is_unsigned = op[2];
        case (op[1:0])
            2'b00:   d.size = SZ_BYTE;
            2'b01:   d.size = SZ_HALF;
            default: d.size = SZ_WORD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store data/byte-enable placement, load extraction, alignment check.
module mem_align
    import rvcpu::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = load_word[{addr_lo, 3'b000} +: 8];
        half_sel   = load_word[{addr_lo[1], 4'b0000} +: 16];
        wdata      = store_data;
        be         = 4'b1111;
        load_data  = load_word;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata     = {4{store_data[7:0]}};
                be        = 4'b0001 << addr_lo;
                load_data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                wdata      = {2{store_data[15:0]}};
                be         = 4'b0011 << addr_lo;
                load_data  = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// rvcpu memory stage: issues loads/stores over a valid/ready dmem port and
// registers the writeback record; non-memory instructions pass through in one cycle.
module stage_mem
    import rvcpu::*;
#(
    parameter int Width = rvcpu::Width
) (
    input  logic             clk,
    input  logic             rst,
    input  stage_ex_t        in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic             dmem_we,
    output logic [Width-1:0] dmem_addr,
    output logic [Width-1:0] dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_rsp_valid,
    input  logic [Width-1:0] dmem_rsp_data,
    output stage_mem_t       out,
    output logic             out_valid
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t     state_q, state_d;
    mem_op_t    in_op;
    logic       pass_en, latch_en, store_done, load_done;

    logic [1:0] al_addr;
    mem_size_t  al_size;
    logic       al_unsigned;
    logic [31:0] al_wdata, al_load;
    logic [3:0] al_be;
    logic       al_mis;
    logic       pass_mis;

    logic [31:0] pc_p1;
    logic [4:0]  rd_p1;
    logic        rd_valid_p1;
    logic [1:0]  addr_lo_p1;
    mem_size_t   size_p1;
    logic        unsigned_p1;
    logic        we_p1;
    logic [31:0] addr_p1, wdata_p1;
    logic [3:0]  be_p1;
    stage_mem_t  out_p2;
    logic        vld_p2;

    assign in_op = decode_op(in.op);

    // In IDLE the aligner checks the incoming op; otherwise it extracts from the latched access.
    always_comb begin
        if (state_q == IDLE) begin
            al_addr     = in.addr[1:0];
            al_size     = in_op.size;
            al_unsigned = in_op.is_unsigned;
        end else begin
            al_addr     = addr_lo_p1;
            al_size     = size_p1;
            al_unsigned = unsigned_p1;
        end
    end

    mem_align u_align (
        .addr_lo     (al_addr),
        .size        (al_size),
        .is_unsigned (al_unsigned),
        .store_data  (in.data),
        .load_word   (dmem_rsp_data),
        .wdata       (al_wdata),
        .be          (al_be),
        .load_data   (al_load),
        .misaligned  (al_mis)
    );

    assign pass_mis = in.is_mem & al_mis;

    always_comb begin
        state_d    = state_q;
        pass_en    = 1'b0;
        latch_en   = 1'b0;
        store_done = 1'b0;
        load_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in.is_mem && !al_mis) begin
                        latch_en = 1'b1;
                        state_d  = REQ;
                    end else begin
                        pass_en = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    if (we_p1) begin
                        store_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rsp_valid) begin
                    load_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: latched request and writeback metadata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_p1       <= '0;
            rd_p1       <= '0;
            rd_valid_p1 <= 1'b0;
            addr_lo_p1  <= '0;
            size_p1     <= SZ_BYTE;
            unsigned_p1 <= 1'b0;
            we_p1       <= 1'b0;
            addr_p1     <= '0;
            wdata_p1    <= '0;
            be_p1       <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                pc_p1       <= in.pc;
                rd_p1       <= in.rd;
                rd_valid_p1 <= in.rd_valid;
                addr_lo_p1  <= in.addr[1:0];
                size_p1     <= in_op.size;
                unsigned_p1 <= in_op.is_unsigned;
                we_p1       <= in_op.store;
                addr_p1     <= {in.addr[31:2], 2'b00};
                wdata_p1    <= in_op.store ? al_wdata : '0;
                be_p1       <= in_op.store ? al_be : 4'b1111;
            end
        end
    end

    // Stage p2: writeback record register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_p2 <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= pass_en | store_done | load_done;
            if (pass_en) begin
                out_p2.pc         <= in.pc;
                out_p2.rd         <= in.rd;
                out_p2.rd_valid   <= in.rd_valid & ~pass_mis;
                out_p2.data       <= pass_mis ? 32'b0 : in.data;
                out_p2.misaligned <= pass_mis;
            end else if (store_done || load_done) begin
                out_p2.pc         <= pc_p1;
                out_p2.rd         <= rd_p1;
                out_p2.rd_valid   <= load_done & rd_valid_p1;
                out_p2.data       <= load_done ? al_load : 32'b0;
                out_p2.misaligned <= 1'b0;
            end
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign dmem_req_valid = (state_q == REQ);
    assign dmem_we        = we_p1;
    assign dmem_addr      = addr_p1;
    assign dmem_wdata     = wdata_p1;
    assign dmem_be        = be_p1;
    assign out            = out_p2;
    assign out_valid      = vld_p2;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: expected writeback records are queued at issue and
// checked by an independent monitor whenever out_valid pulses.
module tb_stage_mem;
    import rvcpu::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    stage_ex_t   in  = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rsp_data = '0;
    stage_mem_t  out;
    logic        out_valid;

    int checks = 0;
    int passes = 0;
    stage_mem_t exp_q[$];

    stage_mem #(.Width(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in             (in),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_data  (dmem_rsp_data),
        .out            (out),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic stage_ex_t mk_ex(input logic [31:0] pc, input logic [31:0] data,
                                        input logic [4:0] rd, input logic is_mem,
                                        input logic [3:0] op, input logic [31:0] addr);
        stage_ex_t e;
        e.pc = pc; e.data = data; e.rd = rd; e.rd_valid = 1'b1;
        e.is_mem = is_mem; e.op = op; e.addr = addr;
        return e;
    endfunction

    function automatic stage_mem_t mk_out(input logic [31:0] pc, input logic [4:0] rd,
                                          input logic rdv, input logic [31:0] data,
                                          input logic mis);
        stage_mem_t o;
        o.pc = pc; o.rd = rd; o.rd_valid = rdv; o.data = data; o.misaligned = mis;
        return o;
    endfunction

    // Monitor: every out_valid pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 128'(out), 128'(0));
                end else begin
                    stage_mem_t e;
                    e = exp_q.pop_front();
                    chk("wb_record", 128'(out), 128'(e));
                end
            end
        end
    end

    // Present one instruction for one cycle; caller guarantees the stage is IDLE.
    task automatic issue(input stage_ex_t e);
        in       = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_load(input string name, input logic [31:0] pc, input logic [3:0] op,
                           input logic [31:0] addr, input logic [31:0] rsp,
                           input logic [31:0] exp_data);
        exp_q.push_back(mk_out(pc, 5'd7, 1'b1, exp_data, 1'b0));
        @(posedge clk); #1;
        issue(mk_ex(pc, 32'hDEAD_0000, 5'd7, 1'b1, op, addr));
        chk({name, "_req_valid"}, 128'(dmem_req_valid), 128'(1));
        chk({name, "_addr"}, 128'(dmem_addr), 128'({addr[31:2], 2'b00}));
        chk({name, "_we_be"}, 128'({dmem_we, dmem_be}), 128'({1'b0, 4'b1111}));
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = rsp;
        @(negedge clk);
        chk({name, "_in_ready_wait"}, 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk({name, "_out_valid"}, 128'({out_valid, in_ready}), 128'(2'b11));
    endtask

    task automatic do_store(input string name, input logic [31:0] pc, input logic [3:0] op,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                            input int stall);
        exp_q.push_back(mk_out(pc, 5'd9, 1'b0, 32'h0, 1'b0));
        @(posedge clk); #1;
        issue(mk_ex(pc, data, 5'd9, 1'b1, op, addr));
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            chk({name, "_req"}, 128'({dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata}),
                128'({1'b1, 1'b1, exp_be, {addr[31:2], 2'b00}, exp_wdata}));
            chk({name, "_in_ready_low"}, 128'({in_ready, out_valid}), 128'(0));
        end
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        chk({name, "_done"}, 128'({out_valid, in_ready, dmem_req_valid}), 128'(3'b110));
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ctrl", 128'({in_ready, dmem_req_valid, out_valid}), 128'(3'b100));
        chk("rst_dmem", 128'({dmem_we, dmem_addr, dmem_wdata, dmem_be}), 128'(0));
        chk("rst_out", 128'(out), 128'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Pass-through
        exp_q.push_back(mk_out(32'h0000_0040, 5'd5, 1'b1, 32'h1234_5678, 1'b0));
        @(posedge clk); #1;
        issue(mk_ex(32'h0000_0040, 32'h1234_5678, 5'd5, 1'b0, 4'b0000, 32'h0000_0003));
        chk("pass_out_valid", 128'({out_valid, dmem_req_valid, in_ready}), 128'(3'b101));

        // Loads
        do_load("lb",  32'h50, 4'b0000, 32'h0000_0103, 32'h80AA_BBCC, 32'hFFFF_FF80);
        do_load("lbu", 32'h54, 4'b0100, 32'h0000_0103, 32'h80AA_BBCC, 32'h0000_0080);
        do_load("lh",  32'h58, 4'b0001, 32'h0000_0102, 32'h80AA_BBCC, 32'hFFFF_80AA);
        do_load("lhu", 32'h5C, 4'b0101, 32'h0000_0100, 32'h80AA_BBCC, 32'h0000_BBCC);
        do_load("lw",  32'h60, 4'b0010, 32'h0000_0104, 32'h80AA_BBCC, 32'h80AA_BBCC);

        // Stores
        do_store("sh", 32'h70, 4'b1001, 32'h0000_0202, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100, 3);
        do_store("sb", 32'h74, 4'b1000, 32'h0000_0501, 32'h1234_56A5, 32'hA5A5_A5A5, 4'b0010, 0);
        do_store("sw", 32'h78, 4'b1010, 32'h0000_0604, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 1);

        // Misaligned LW
        exp_q.push_back(mk_out(32'h80, 5'd7, 1'b0, 32'h0, 1'b1));
        @(posedge clk); #1;
        issue(mk_ex(32'h80, 32'h1111_2222, 5'd7, 1'b1, 4'b0010, 32'h0000_0301));
        chk("mis_no_req", 128'({dmem_req_valid, out_valid, in_ready}), 128'(3'b011));

        // Reset while a load is outstanding
        @(posedge clk); #1;
        issue(mk_ex(32'h90, 32'h0, 5'd3, 1'b1, 4'b0010, 32'h0000_0400));
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_wait_ctrl", 128'({dmem_req_valid, in_ready, out_valid}), 128'(3'b010));
        @(posedge clk); #1 rst = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'h5555_AAAA;
        @(posedge clk); #1 dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stray_rsp", 128'({out_valid, in_ready}), 128'(2'b01));

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: timeout reached, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory stage of the rvcpu pipeline. Consumes the execute-stage result (`rvcpu::stage_ex_t`), performs loads and stores on the data-memory port through a valid/ready request and response handshake, and forwards a registered writeback record (`rvcpu::stage_mem_t`). Non-memory instructions pass through with one cycle of latency. The stage stalls upstream through `in_ready` while a memory access is outstanding.

## Interface
Parameters:
- `Width`, default `rvcpu::Width` (32): data and address width. Only 32 is supported.

Ports:
- `clk` in 1: clock. One clock domain; all state updates on the rising edge.
- `rst` in 1: reset. Asynchronous and active-high.
- `in` in `rvcpu::stage_ex_t`: execute result, with fields `pc`, `data`, `rd`, `rd_valid`, `is_mem`, `op`, `addr`.
- `in_valid` in 1: `in` holds a valid instruction.
- `in_ready` out 1: the stage accepts `in` this cycle.
- `dmem_req_valid` out 1: memory request is valid.
- `dmem_req_ready` in 1: memory accepts the request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out `Width`: word-aligned address, equal to `in.addr & ~3`.
- `dmem_wdata` out `Width`: store data shifted into the addressed lanes.
- `dmem_be` out 4: byte enables for stores; 4'b1111 for loads.
- `dmem_rsp_valid` in 1: load data is valid.
- `dmem_rsp_data` in `Width`: raw loaded word.
- `out` out `rvcpu::stage_mem_t`: writeback record, with fields `pc`, `rd`, `rd_valid`, `data`, `misaligned`.
- `out_valid` out 1: one-cycle pulse; `out` is new this cycle.

## Operation
- Memory op encoding:
  - `op[3]` = 1 is a store, 0 is a load.
  - `op[2:0]` is funct3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- Alignment:
  - A half-word access requires `addr[0]` = 0.
  - A word access requires `addr[1:0]` = 0.
  - A misaligned access issues no memory request. It sets `out.misaligned`=1 and `out.rd_valid`=0, and completes with pass-through latency.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: `in_ready`=1. On accept, a non-mem or misaligned instruction goes to the output register (stay IDLE). An aligned mem instruction latches the request and goes to REQ.
  - REQ: `dmem_req_valid`=1, with request fields held stable. On `dmem_req_ready`, a store completes (goes to the output register, then IDLE) and a load goes to WAIT.
  - WAIT: on `dmem_rsp_valid`, the extracted load data goes to the output register, then IDLE.
- Load extraction:
  - Select the byte or half at `addr[1:0]` or `addr[1]`.
  - Sign-extend or zero-extend per funct3.
- Store lane placement:
  - byte: `wdata` = {4{b}}, `be` = 1 << `addr[1:0]`.
  - half: `wdata` = {2{h}}, `be` = 2'b11 << `addr[1:0]`.
  - word: `be` = 4'b1111.
- `out.data`:
  - Loads: the extracted value.
  - Non-mem: `in.data`.
  - Stores: `out.data` = 0 and `out.rd_valid` = 0.
- `dmem_rsp_valid` outside WAIT is ignored.

## Timing
- Reset values: state IDLE, `in_ready`=1, `dmem_req_valid`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `dmem_be`=0, `out_valid`=0, all `out` fields 0.
- Non-mem or misaligned instruction accepted in cycle N: `out_valid`=1 in cycle N+1.
- Load accepted in cycle N:
  - `dmem_req_valid`=1 from cycle N+1.
  - The request handshake in cycle R moves the FSM to WAIT.
  - `rsp_valid` in cycle S gives `out_valid`=1 in cycle S+1. S may equal R+1 at the earliest.
- Store accepted in cycle N: handshake in cycle R gives `out_valid`=1 in cycle R+1.
- Back-to-back issue:
  - `in_ready`=1 only in IDLE, so a pass-through instruction can be accepted every cycle.
  - After a mem op, the next accept is possible in the cycle the FSM returns to IDLE, which is the same cycle `out_valid` fires.
- `dmem_req_valid` is never withdrawn before `dmem_req_ready`, and the request fields are stable while it is asserted.
- `rst` mid-access returns the FSM to IDLE immediately. The outstanding access is abandoned, and the memory side must tolerate the dropped request.

## Structure
- Add `rvcpu::stage_mem_t` to the package, plus `mem_size_t` (byte, half, word) and a helper that decodes `op` into {store, size, unsigned}.
- One sub-module, `mem_align`, kept combinational:
  - Inputs: `addr[1:0]`, size, unsigned, store data, raw load word.
  - Outputs: `wdata`, `be`, extracted load data, `misaligned`.
- The FSM and the output register live in `stage_mem`.

## Test plan
- Pass-through:
  - Stimulus: non-mem `in` with `data`=0x1234_5678, `rd`=5, `rd_valid`=1.
  - Response: next cycle `out_valid`=1, `out.data`=0x1234_5678, `out.rd`=5, no dmem request.
- LB sign-extend:
  - Stimulus: `addr`=0x103, memory returns 0x80AA_BBCC.
  - Response: `dmem_addr`=0x100, `out.data`=0xFFFF_FF80.
- LBU with the same access:
  - Response: `out.data`=0x0000_0080.
- SH:
  - Stimulus: `addr`=0x202, `in.data`=0x0000_BEEF, with `dmem_req_ready` held low for 3 cycles.
  - Response: request held stable with `wdata`=0xBEEF_BEEF and `be`=4'b1100. `in_ready`=0 throughout. `out_valid` fires one cycle after the handshake with `rd_valid`=0.
- Misaligned LW:
  - Stimulus: `addr`=0x301.
  - Response: no `dmem_req_valid`. Next cycle `out.misaligned`=1, `rd_valid`=0.
- Reset in WAIT:
  - Stimulus: assert `rst` with a load outstanding.
  - Response: `dmem_req_valid`=0, `in_ready`=1, `out_valid`=0 immediately. A later stray `rsp_valid` produces no `out_valid`.
